mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported memory bus between the fetch stage (IF) and the
//   memory stage (DM) of the 5-stage pipeline. Registers and sequences one
//   transaction at a time, returns read data/completion to the owner, drives
//   per-stage stall lines to the hazard logic, and aborts hung accesses.
// PARAMETERS
//   ADDR_W    32   address width, all address ports
//   DATA_W    32   data width; byte enables are DATA_W/8 bits
//   MAX_WAIT  16   cycles in BUSY without mem_ack_i before abort (>=2)
// PORTS
//   clk_i        in   1         clock, rising edge
//   reset_i      in   1         synchronous, active-low reset
//   if_req_i     in   1         fetch request; hold with addr until if_gnt_o
//   if_addr_i    in   ADDR_W    fetch address
//   if_gnt_o     out  1         fetch request accepted this cycle
//   if_rvalid_o  out  1         one-cycle pulse: if_rdata_o valid
//   if_rdata_o   out  DATA_W    fetched instruction
//   dm_req_i     in   1         data request; hold with fields until dm_gnt_o
//   dm_we_i      in   1         1 = store, 0 = load
//   dm_addr_i    in   ADDR_W    data address
//   dm_wdata_i   in   DATA_W    store data
//   dm_be_i      in   DATA_W/8  store byte enables
//   dm_gnt_o     out  1         data request accepted this cycle
//   dm_rvalid_o  out  1         one-cycle pulse: load data valid / store done
//   dm_rdata_o   out  DATA_W    load data (0 for stores)
//   mem_req_o    out  1         bus request, held until ack or abort
//   mem_we_o     out  1         bus write enable
//   mem_addr_o   out  ADDR_W    bus address
//   mem_wdata_o  out  DATA_W    bus write data
//   mem_be_o     out  DATA_W/8  bus byte enables (all-ones for reads)
//   mem_ack_i    in   1         bus completion; mem_rdata_i valid same cycle
//   mem_rdata_i  in   DATA_W    bus read data
//   stall_if_o   out  1         if_req_i & ~if_rvalid_o
//   stall_mem_o  out  1         dm_req_i & ~dm_rvalid_o
//   timeout_o    out  1         sticky: an access was aborted
// BEHAVIOUR
//   Reset (reset_i low at edge): state IDLE, every registered output 0,
//     last_owner=IF, wait counter 0, timeout_o 0; in-flight access dropped,
//     a later mem_ack_i for it is ignored. Reset takes priority over all.
//   FSM: IDLE -> BUSY_IF | BUSY_DM on grant; BUSY_x -> IDLE on ack or abort.
//   Grant (combinational, IDLE only): DM only -> DM; IF only -> IF; both ->
//     the one NOT equal to last_owner (alternation, no starvation). gnt_o
//     asserted in that IDLE cycle; addr/we/wdata/be latched at the edge.
//   mem_req_o and latched fields registered: high from cycle after grant,
//     stable until the ack cycle inclusive; mem_be_o=all-ones, mem_we_o=0 for IF.
//   On mem_ack_i in BUSY_x: capture mem_rdata_i; next cycle x_rvalid_o=1 for
//     exactly one cycle, mem_req_o=0, state IDLE. New grant possible in that
//     same cycle -> min. 3 cycles grant-to-grant. Ack outside BUSY ignored.
//   rdata outputs hold their value until the next rvalid of that port.
//   Wait counter: cleared on grant, +1 each BUSY cycle without ack; when it
//     reaches MAX_WAIT-1 with no ack: abort -> mem_req_o=0, IDLE, owner's
//     rvalid pulses with rdata=0, timeout_o set until reset. Ack arriving on
//     the abort cycle wins (normal completion, no timeout).
//   Requests withdrawn before grant are legal and produce no bus activity.
//   last_owner updated on every grant.
// TESTING
//   IF read, ack 2 cycles after mem_req_o, rdata 0x00500093 -> if_rvalid_o
//     1 cycle after ack, if_rdata_o=0x00500093, stall_if_o low that cycle.
//   DM store addr 0x100 data 0xDEADBEEF be 4'b0011 -> bus shows exact fields,
//     mem_we_o=1, dm_rvalid_o pulses, dm_rdata_o=0.
//   IF and DM held continuously, ack 1 cycle -> grants alternate DM,IF,DM..
//     (last_owner=IF after reset), grant-to-grant 3 cycles.
//   No ack, MAX_WAIT=16 -> mem_req_o drops after 16 BUSY cycles, rvalid pulse
//     with rdata=0, timeout_o=1 and stays 1; next request served normally.
//   reset_i low mid-BUSY, then ack arrives -> all outputs 0, no rvalid pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported memory bus between the instruction fetch stage
//   (IF) and the memory stage (DM). Only one bus transaction is in flight at a
//   time. When both stages request in the same IDLE cycle, the grant goes to
//   whichever stage did not own the previous grant, so neither can starve.
//   Read data and completion are returned to the owner as a one-cycle rvalid
//   pulse. Per-stage stall lines go to the hazard unit. An access that is never
//   acknowledged is aborted after MAX_WAIT busy cycles, and a sticky timeout
//   flag records that this happened.
//
// Ports
//   clk_i, reset_i            clock (rising edge), synchronous active-low reset
//   if_req_i / if_addr_i      fetch request; held until if_gnt_o
//   if_gnt_o                  fetch accepted this cycle (combinational)
//   if_rvalid_o / if_rdata_o  fetch completion pulse and instruction word
//   dm_req_i, dm_we_i,
//   dm_addr_i, dm_wdata_i,
//   dm_be_i                   load/store request; held until dm_gnt_o
//   dm_gnt_o                  data request accepted this cycle (combinational)
//   dm_rvalid_o / dm_rdata_o  load data / store done pulse (data 0 for stores)
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o,
//   mem_be_o                  registered bus request, held until ack or abort
//   mem_ack_i / mem_rdata_i   bus completion with same-cycle read data
//   stall_if_o, stall_mem_o   request pending and not completing this cycle
//   timeout_o                 sticky: some access was aborted since reset
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    // fetch port
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    // data port
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    output logic                dm_gnt_o,
    output logic                dm_rvalid_o,
    output logic [DATA_W-1:0]   dm_rdata_o,
    // memory bus
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    // hazard / status
    output logic                stall_if_o,
    output logic                stall_mem_o,
    output logic                timeout_o
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    state_e              state_q,     state_d;
    owner_e              last_q,      last_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q,    mem_be_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic                dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;
    logic                timeout_q,   timeout_d;

    // DM wins when it is the only requester, or when both request and IF
    // held the previous grant.
    logic pick_dm;
    assign pick_dm = dm_req_i & (~if_req_i | (last_q == OWN_IF));

    // Completion of the current access: a real ack, or the last allowed busy
    // cycle without one. An ack on that last cycle still counts as a normal
    // completion.
    logic done, abort;
    assign done  = mem_ack_i | (cnt_q == CNT_LAST);
    assign abort = ~mem_ack_i;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rvalid_d = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        timeout_d   = timeout_q;
        if_gnt_o    = 1'b0;
        dm_gnt_o    = 1'b0;

        case (state_q)
            IDLE: begin
                // No grant is advertised while reset is being applied.
                if (reset_i && (if_req_i || dm_req_i)) begin
                    mem_req_d = 1'b1;
                    cnt_d     = '0;
                    if (pick_dm) begin
                        dm_gnt_o    = 1'b1;
                        state_d     = BUSY_DM;
                        last_d      = OWN_DM;
                        mem_we_d    = dm_we_i;
                        mem_addr_d  = dm_addr_i;
                        // Loads drive no write data and enable every byte.
                        mem_wdata_d = dm_we_i ? dm_wdata_i : '0;
                        mem_be_d    = dm_we_i ? dm_be_i    : '1;
                    end else begin
                        if_gnt_o    = 1'b1;
                        state_d     = BUSY_IF;
                        last_d      = OWN_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                        mem_be_d    = '1;
                    end
                end
            end

            BUSY_IF, BUSY_DM: begin
                if (done) begin
                    // Bus goes quiet between accesses.
                    state_d     = IDLE;
                    cnt_d       = '0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_be_d    = '0;
                    if (abort) timeout_d = 1'b1;
                    if (state_q == BUSY_IF) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = abort ? '0 : mem_rdata_i;
                    end else begin
                        dm_rvalid_d = 1'b1;
                        // Stores complete with zero data.
                        dm_rdata_d  = (abort || mem_we_q) ? '0 : mem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            last_q      <= OWN_IF;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rvalid_q <= 1'b0;
            dm_rdata_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rvalid_q <= dm_rvalid_d;
            dm_rdata_q  <= dm_rdata_d;
            timeout_q   <= timeout_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rvalid_o = dm_rvalid_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign timeout_o   = timeout_q;

    assign stall_if_o  = if_req_i & ~if_rvalid_q;
    assign stall_mem_o = dm_req_i & ~dm_rvalid_q;

endmodule
